snitch_icache_flush_ctrl: RTL and testbench

//   Sequences L1 instruction-cache flushes requested by NR_PORTS fetch ports.

---
 rtl/snitch_icache_flush_ctrl_if.sv | 53 +++++
 rtl/snitch_icache_flush_ctrl.sv | 148 ++++++++++++++
 tb/tb_snitch_icache_flush_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/snitch_icache_flush_ctrl_if.sv
// Flush-controller signal bundle between fetch ports, lookup stage and refill engine.
// Latency: none; this is a plain wire bundle.
// Backpressure: flush_valid_i/flush_ready_o and cache_flush_valid_o/cache_flush_ready_i handshakes.
//
// Modports:
//   slave  - the flush controller (consumes requests, drives gate/acks/flush)
//   master - the surrounding fetch/lookup/refill logic
interface snitch_icache_flush_ctrl_if #(
    parameter int unsigned NR_PORTS = 4,
    parameter int unsigned CNT_W    = 16
) ();
    // Per-port flush request/ack.
    logic [NR_PORTS-1:0] flush_valid_i;
    logic [NR_PORTS-1:0] flush_ready_o;
    // Lookup-stage traffic observation and gating.
    logic                lookup_gate_o;
    logic                lookup_req_i;
    logic                lookup_rsp_i;
    // Refill engine status.
    logic                refill_pending_i;
    // Flush handshake towards the lookup stage.
    logic                cache_flush_valid_o;
    logic                cache_flush_ready_i;
    // Status.
    logic                busy_o;
    logic [CNT_W-1:0]    flush_count_o;

    modport slave (
        input  flush_valid_i,
        output flush_ready_o,
        output lookup_gate_o,
        input  lookup_req_i,
        input  lookup_rsp_i,
        input  refill_pending_i,
        output cache_flush_valid_o,
        input  cache_flush_ready_i,
        output busy_o,
        output flush_count_o
    );

    modport master (
        output flush_valid_i,
        input  flush_ready_o,
        input  lookup_gate_o,
        output lookup_req_i,
        output lookup_rsp_i,
        output refill_pending_i,
        input  cache_flush_valid_o,
        output cache_flush_ready_i,
        input  busy_o,
        input  flush_count_o
    );
endinterface

// File: rtl/snitch_icache_flush_ctrl.sv
// Sequences batched L1 I-cache flushes: gate lookups, drain, flush, wait tag re-init, ack.
// Latency: request-to-ack >= LINE_COUNT+12 cycles less 8 (DRAIN>=1, FLUSH>=1, INIT LINE_COUNT+1, ACK 1).
// Backpressure: holds cache_flush_valid_o until cache_flush_ready_i; ports hold flush_valid_i until acked.
//
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   bus (slave)    - flush_valid_i/flush_ready_o per port, lookup_gate_o, lookup_req_i,
//                    lookup_rsp_i, refill_pending_i, cache_flush_valid_o/cache_flush_ready_i,
//                    busy_o, flush_count_o (saturating count of completed rounds)
module snitch_icache_flush_ctrl #(
    parameter int unsigned NR_PORTS        = 4,
    parameter int unsigned LINE_COUNT      = 128,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    snitch_icache_flush_ctrl_if.slave bus
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TMR_W = $clog2(LINE_COUNT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        FLUSH = 3'd2,
        INIT  = 3'd3,
        ACK   = 3'd4
    } state_e;

    state_e              state_q;
    logic [NR_PORTS-1:0] pending_q;
    logic [OUT_W-1:0]    outst_q;
    logic [TMR_W-1:0]    timer_q;
    logic [NR_PORTS-1:0] ready_q;
    logic                flush_vld_q;
    logic                busy_q;
    logic [CNT_W-1:0]    count_q;

    // ------------------------------------------------------------------
    // In-flight lookup counter. Simultaneous in/out handshakes cancel.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q <= '0;
        end else if (bus.lookup_req_i && !bus.lookup_rsp_i) begin
            outst_q <= outst_q + 1'b1;
        end else if (!bus.lookup_req_i && bus.lookup_rsp_i) begin
            outst_q <= outst_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Gate is combinational so that a port raising a flush request stops
    // new lookups in that very cycle, before the FSM has latched it.
    // ------------------------------------------------------------------
    assign bus.lookup_gate_o = (state_q == IDLE)
                             && !(|bus.flush_valid_i)
                             && (outst_q < OUT_W'(MAX_OUTSTANDING));

    // ------------------------------------------------------------------
    // Flush sequencer. All handshake outputs are registered and change on
    // the same edge as the state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            timer_q     <= '0;
            ready_q     <= '0;
            flush_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            ready_q <= '0;
            unique case (state_q)
                IDLE: begin
                    // Snapshot of requesters; later arrivals wait for the next round.
                    if (|bus.flush_valid_i) begin
                        pending_q <= bus.flush_valid_i;
                        busy_q    <= 1'b1;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Registered outst_q: a response seen this cycle only counts next cycle.
                    if (outst_q == '0 && !bus.refill_pending_i) begin
                        flush_vld_q <= 1'b1;
                        state_q     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (bus.cache_flush_ready_i) begin
                        flush_vld_q <= 1'b0;
                        timer_q     <= TMR_W'(LINE_COUNT);
                        state_q     <= INIT;
                    end
                end
                INIT: begin
                    // Counting LINE_COUNT down to 0 inclusive spans LINE_COUNT+1 cycles.
                    if (timer_q == '0) begin
                        ready_q <= pending_q;
                        state_q <= ACK;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ACK: begin
                    pending_q <= '0;
                    busy_q    <= 1'b0;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_q <= count_q + 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    pending_q   <= '0;
                    flush_vld_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flush_ready_o       = ready_q;
    assign bus.cache_flush_valid_o = flush_vld_q;
    assign bus.busy_o              = busy_q;
    assign bus.flush_count_o       = count_q;

    // ------------------------------------------------------------------
    // Protocol checks on the surrounding logic.
    // ------------------------------------------------------------------
    a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pending_q & ~ready_q & ~bus.flush_valid_i) == '0);

    // A lookup may slip through only in the cycle a new flush request closes the gate.
    a_req_gated: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.lookup_req_i |-> (bus.lookup_gate_o || (state_q == IDLE && |bus.flush_valid_i)));

    a_rsp_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.lookup_rsp_i |-> (outst_q != '0));

    a_outst_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outst_q <= OUT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_snitch_icache_flush_ctrl.sv
module tb_snitch_icache_flush_ctrl;

    localparam int NP = 4;
    localparam int LC = 8;
    localparam int MO = 2;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snitch_icache_flush_ctrl_if #(.NR_PORTS(NP), .CNT_W(CW)) bus ();

    snitch_icache_flush_ctrl #(
        .NR_PORTS(NP), .LINE_COUNT(LC), .MAX_OUTSTANDING(MO), .CNT_W(CW)
    ) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            if (n_err < 40) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a round is described by time stamps (latch cycle,
    // drain-complete cycle, handshake cycle); outputs follow from them.
    // ------------------------------------------------------------------
    int          cyc = 0;
    bit          m_in_round;
    logic [NP-1:0] m_mask;
    int          m_drain, m_hs, m_outst, m_count;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_in_round = 0; m_mask = '0; m_drain = -1; m_hs = -1; m_outst = 0; m_count = 0;
        end else begin
            // expectations for this cycle
            chk("busy",  bus.busy_o, m_in_round);
            chk("cfv",   bus.cache_flush_valid_o, m_in_round && m_drain >= 0 && m_hs < 0);
            chk("ready", bus.flush_ready_o,
                (m_in_round && m_hs >= 0 && cyc == m_hs + LC + 2) ? m_mask : '0);
            chk("gate",  bus.lookup_gate_o,
                !m_in_round && bus.flush_valid_i == '0 && m_outst < MO);
            chk("count", bus.flush_count_o, m_count);
            // advance to the next cycle
            if (!m_in_round) begin
                if (|bus.flush_valid_i) begin
                    m_in_round = 1; m_mask = bus.flush_valid_i; m_drain = -1; m_hs = -1;
                end
            end else if (m_drain < 0) begin
                if (m_outst == 0 && !bus.refill_pending_i) m_drain = cyc;
            end else if (m_hs < 0) begin
                if (bus.cache_flush_ready_i) m_hs = cyc;
            end else if (cyc == m_hs + LC + 2) begin
                m_in_round = 0;
                if (m_count < (1 << CW) - 1) m_count++;
            end
            m_outst += int'(bus.lookup_req_i) - int'(bus.lookup_rsp_i);
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.flush_valid_i = '0; bus.lookup_req_i = 0; bus.lookup_rsp_i = 0;
        bus.refill_pending_i = 0; bus.cache_flush_ready_i = 0;
        step(); step();
        rst_n = 1'b1;
    endtask

    // Request cycle is k=0 (set by the caller); follows the round until the ack.
    task automatic watch(input int rsp_a, input int rsp_b, input int refill_until,
                         input int raise_k, input logic [NP-1:0] raise_m,
                         output int ack_k, output logic [NP-1:0] ack_m,
                         output int cfv_k, output int cfv_n, output int gate_open_n);
        ack_k = -1; ack_m = '0; cfv_k = -1; cfv_n = 0; gate_open_n = 0;
        for (int k = 1; k <= 80; k++) begin
            step();
            bus.lookup_rsp_i     = (k == rsp_a) || (k == rsp_b);
            bus.refill_pending_i = (k < refill_until);
            if (k == raise_k) bus.flush_valid_i = bus.flush_valid_i | raise_m;
            @(negedge clk);
            if (bus.cache_flush_valid_o) begin
                if (cfv_k < 0) cfv_k = k;
                cfv_n++;
            end
            if (cfv_k < 0 && bus.lookup_gate_o) gate_open_n++;
            if (bus.flush_ready_o != '0) begin
                ack_k = k; ack_m = bus.flush_ready_o;
                break;
            end
        end
        bus.lookup_rsp_i = 0;
        bus.refill_pending_i = 0;
    endtask

    int            ak, ck, cn, gn;
    logic [NP-1:0] am;
    logic [NP-1:0] ack_seen;
    logic [NP-1:0] v;

    initial begin
        bus.flush_valid_i = '0; bus.lookup_req_i = 0; bus.lookup_rsp_i = 0;
        bus.refill_pending_i = 0; bus.cache_flush_ready_i = 0;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_gate", bus.lookup_gate_o, 1);
        chk("rst_ready", bus.flush_ready_o, 0);
        chk("rst_cfv", bus.cache_flush_valid_o, 0);
        chk("rst_count", bus.flush_count_o, 0);

        // single port, no traffic: DRAIN k=1, FLUSH k=2, INIT k=3..11, ACK k=12
        step();
        bus.cache_flush_ready_i = 1; bus.flush_valid_i = 4'b0001;
        watch(-1, -1, 0, -1, '0, ak, am, ck, cn, gn);
        chk("t1_ack_cycle", ak, 12);
        chk("t1_ack_mask", am, 4'b0001);
        chk("t1_cfv_cycle", ck, 2);
        step(); bus.flush_valid_i = '0;
        @(negedge clk);
        chk("t1_count", bus.flush_count_o, 1);

        // two ports in one batch
        do_reset();
        step();
        bus.cache_flush_ready_i = 1; bus.flush_valid_i = 4'b1010;
        watch(-1, -1, 0, -1, '0, ak, am, ck, cn, gn);
        chk("t2_cfv_pulses", cn, 1);
        chk("t2_ack_mask", am, 4'b1010);
        step(); bus.flush_valid_i = '0;

        // two lookups in flight, responses at k=3 and k=5
        do_reset();
        step(); bus.lookup_req_i = 1;
        step(); bus.lookup_req_i = 1;
        step(); bus.lookup_req_i = 0;
        bus.cache_flush_ready_i = 1; bus.flush_valid_i = 4'b0001;
        watch(3, 5, 0, -1, '0, ak, am, ck, cn, gn);
        chk("t3_cfv_cycle", ck, 7);
        chk("t3_ack_cycle", ak, 17);
        step(); bus.flush_valid_i = '0;

        // refill pending for 10 cycles (k=0..9): DRAIN k=1..10, FLUSH k=11
        do_reset();
        step();
        bus.cache_flush_ready_i = 1; bus.refill_pending_i = 1; bus.flush_valid_i = 4'b0001;
        watch(-1, -1, 10, -1, '0, ak, am, ck, cn, gn);
        chk("t4_cfv_cycle", ck, 11);
        chk("t4_gate_open", gn, 0);
        step(); bus.flush_valid_i = '0;

        // port2 arrives during INIT of port0's round
        do_reset();
        step();
        bus.cache_flush_ready_i = 1; bus.flush_valid_i = 4'b0001;
        watch(-1, -1, 0, 5, 4'b0100, ak, am, ck, cn, gn);
        chk("t5_first_mask", am, 4'b0001);
        step(); bus.flush_valid_i = bus.flush_valid_i & ~am;
        watch(-1, -1, 0, -1, '0, ak, am, ck, cn, gn);
        chk("t5_second_mask", am, 4'b0100);
        chk("t5_second_cycle", ak, 12);
        step(); bus.flush_valid_i = '0;
        @(negedge clk);
        chk("t5_count", bus.flush_count_o, 2);

        // reset during INIT
        step(); bus.flush_valid_i = 4'b0001;
        repeat (5) step();
        rst_n = 1'b0; bus.flush_valid_i = '0;
        @(negedge clk);
        chk("t6_busy", bus.busy_o, 0);
        chk("t6_gate", bus.lookup_gate_o, 1);
        chk("t6_ready", bus.flush_ready_o, 0);
        chk("t6_count", bus.flush_count_o, 0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("t6_cfv_after", bus.cache_flush_valid_o, 0);

        // randomized traffic, checked cycle by cycle by the model
        ack_seen = '0;
        for (int c = 0; c < 4000; c++) begin
            step();
            v = bus.flush_valid_i & ~ack_seen;
            for (int i = 0; i < NP; i++)
                if (!v[i] && $urandom_range(0, 24) == 0) v[i] = 1'b1;
            bus.flush_valid_i = v;
            if ($urandom_range(0, 9) == 0) bus.refill_pending_i = !bus.refill_pending_i;
            bus.cache_flush_ready_i = ($urandom_range(0, 2) != 0);
            bus.lookup_rsp_i = (m_outst > 0) && ($urandom_range(0, 2) == 0);
            bus.lookup_req_i = 0;
            #1;
            bus.lookup_req_i = bus.lookup_gate_o && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            ack_seen = bus.flush_ready_o;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
